// File: rtl/rx_serial_8n1.sv
// rx_serial_8n1: 8N1 serial receiver with mid-bit sampling and a one-cycle delivery pulse.
// Define RX_SERIAL_FRAME_CHECK_EN to gate delivery on the stop bit (erro pulse on a low stop bit).
module rx_serial_8n1 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [7:0] dados_ascii,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro
);
`ifdef RX_SERIAL_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {REPOUSO, INICIO, DADOS, PARADA, ENTREGA} state_t;
    state_t      state, state_n;
    logic        sync_meta, rx;
    logic [15:0] timer, timer_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n, dados_n;
    logic        pronto_n, erro_n;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta   <= 1'b1;
            rx          <= 1'b1;
            state       <= REPOUSO;
            timer       <= '0;
            idx         <= '0;
            shift       <= '0;
            dados_ascii <= '0;
            pronto      <= 1'b0;
            erro        <= 1'b0;
        end else begin
            sync_meta   <= entrada_serial;
            rx          <= sync_meta;
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            shift       <= shift_n;
            dados_ascii <= dados_n;
            pronto      <= pronto_n;
            erro        <= erro_n;
        end
    end
    // pronto/erro are registered on the stop-bit sample, so they are high exactly during ENTREGA
    always_comb begin
        state_n  = state;
        timer_n  = timer + 16'd1;
        idx_n    = idx;
        shift_n  = shift;
        dados_n  = dados_ascii;
        pronto_n = 1'b0;
        erro_n   = 1'b0;
        case (state)
            REPOUSO: begin
                timer_n = '0;
                state_n = rx ? REPOUSO : INICIO;
            end
            INICIO: if (timer == HALF_LAST) begin
                timer_n = '0;
                idx_n   = '0;
                state_n = rx ? REPOUSO : DADOS;
            end
            DADOS: if (timer == BIT_LAST) begin
                timer_n = '0;
                shift_n = {rx, shift[7:1]};
                idx_n   = idx + 3'd1;
                state_n = (idx == 3'd7) ? PARADA : DADOS;
            end
            PARADA: if (timer == BIT_LAST) begin
                timer_n  = '0;
                state_n  = ENTREGA;
                pronto_n = rx || !FRAME_CHECK;
                erro_n   = FRAME_CHECK && !rx;
                dados_n  = pronto_n ? shift : dados_ascii;
            end
            ENTREGA: begin
                timer_n = '0;
                state_n = REPOUSO;
            end
            default: state_n = REPOUSO;
        endcase
    end
    assign ocupado = (state != REPOUSO);
endmodule

// File: tb/tb_rx_serial_8n1.sv
// tb_rx_serial_8n1: scoreboard bench for rx_serial_8n1 at 16 clocks/bit plus a 5208 clocks/bit latency run.
module tb_rx_serial_8n1;
    localparam int C = 16;
    localparam int CB = 5208;
    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic [7:0] dados_a, dados_b;
    logic       pronto_a, pronto_b, ocupado_a, ocupado_b, erro_a, erro_b;
    int         checks = 0, failures = 0, cyc = 0;
    exp_t       q[$];
    int         pt[$];
    bit         prev_pulse = 1'b0;
    int         b_cnt = 0, b_cyc = 0;
    logic [7:0] b_data = '0;
    rx_serial_8n1 #(.CLKS_PER_BIT(C)) dut_a (
        .clock(clock), .reset(reset), .entrada_serial(line_a),
        .dados_ascii(dados_a), .pronto(pronto_a), .ocupado(ocupado_a), .erro(erro_a)
    );
    rx_serial_8n1 #(.CLKS_PER_BIT(CB)) dut_b (
        .clock(clock), .reset(reset), .entrada_serial(line_b),
        .dados_ascii(dados_b), .pronto(pronto_b), .ocupado(ocupado_b), .erro(erro_b)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask
    task automatic set_line(input bit b, input logic v);
        if (b) line_b = v;
        else line_a = v;
    endtask
    // caller is aligned 1ns after a rising edge; frames sent back-to-back have no gap
    task automatic send(input bit b, input logic [7:0] d, input logic stop, input int c, output int t0);
        t0 = cyc;
        set_line(b, 1'b0);
        repeat (c) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            set_line(b, d[i]);
            repeat (c) @(posedge clock);
            #1;
        end
        set_line(b, stop);
        repeat (c) @(posedge clock);
        #1;
        set_line(b, 1'b1);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    always @(negedge clock) begin
        if (prev_pulse) check("idle_after_entrega", ocupado_a, 1'b0);
        prev_pulse = pronto_a || erro_a;
        if (pronto_a || erro_a) begin
            exp_t e;
            check("pronto_erro_exclusive", pronto_a && erro_a, 1'b0);
            check("busy_in_entrega", ocupado_a, 1'b1);
            if (pronto_a) pt.push_back(cyc);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=pronto%0b/erro%0b required=none", pronto_a, erro_a);
            end else begin
                e = q.pop_front();
                check("pulse_kind_erro", erro_a, e.err);
                check("dados_ascii", dados_a, e.d);
            end
        end
    end
    always @(negedge clock) if (pronto_b) begin
        b_cnt++;
        b_cyc = cyc;
        b_data = dados_b;
    end
    initial begin
        int t0, t1;
        idle(4);
        check("rst_dados", dados_a, 8'h00);
        check("rst_pronto", pronto_a, 1'b0);
        check("rst_erro", erro_a, 1'b0);
        check("rst_ocupado", ocupado_a, 1'b0);
        check("rst_b_dados", dados_b, 8'h00);
        check("rst_b_ocupado", ocupado_b, 1'b0);
        reset = 1'b1;
        idle(5);
        q.push_back('{1'b0, 8'h55});
        fork
            send(1'b0, 8'h55, 1'b1, C, t0);
            begin
                repeat (3) @(negedge clock);
                check("busy_before_sync", ocupado_a, 1'b0);
                @(negedge clock);
                check("busy_after_sync", ocupado_a, 1'b1);
            end
        join
        idle(3 * C);
        line_a = 1'b0;
        idle(4);
        line_a = 1'b1;
        @(negedge clock);
        check("glitch_busy", ocupado_a, 1'b1);
        idle(3 * C);
        check("glitch_idle", ocupado_a, 1'b0);
        check("glitch_dados_held", dados_a, 8'h55);
`ifdef RX_SERIAL_FRAME_CHECK_EN
        q.push_back('{1'b1, 8'h55});
`else
        q.push_back('{1'b0, 8'hA3});
`endif
        send(1'b0, 8'hA3, 1'b0, C, t0);
        idle(3 * C);
        pt.delete();
        q.push_back('{1'b0, 8'h00});
        q.push_back('{1'b0, 8'hFF});
        send(1'b0, 8'h00, 1'b1, C, t0);
        send(1'b0, 8'hFF, 1'b1, C, t1);
        idle(C);
        check("b2b_count", pt.size(), 2);
        if (pt.size() == 2) check_range("b2b_gap", pt[1] - pt[0], 10 * C - 1, 10 * C + 1);
        idle(2 * C);
        fork
            send(1'b0, 8'h3C, 1'b1, C, t0);
            begin
                repeat (5 * C + C / 2) @(posedge clock);
                #2 reset = 1'b0;
                #1;
                check("abort_dados", dados_a, 8'h00);
                check("abort_pronto", pronto_a, 1'b0);
                check("abort_erro", erro_a, 1'b0);
                check("abort_ocupado", ocupado_a, 1'b0);
            end
        join
        idle(5);
        reset = 1'b1;
        idle(2 * C);
        check("abort_still_idle", ocupado_a, 1'b0);
        q.push_back('{1'b0, 8'h3C});
        send(1'b0, 8'h3C, 1'b1, C, t0);
        idle(2 * C);
        check("after_abort_dados", dados_a, 8'h3C);
        send(1'b1, 8'h41, 1'b1, CB, t0);
        idle(10);
        check("slow_pulse_count", b_cnt, 1);
        check("slow_dados", b_data, 8'h41);
        check_range("slow_latency", b_cyc - t0, CB * 19 / 2 + 2, CB * 19 / 2 + 4);
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
